pwm_regs: RTL and testbench
===========================

PWM_REGS -- requirements
Module: pwm_regs

Interface
REQ-001 Parameter: WIDTH, 32, width of the bus data and of the period, duty and counter registers.
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: adr  input  32  byte address from the bus initiator; only adr[4:2] is decoded; adr[1:0] and adr[31:5] are ignored.
REQ-005 Port: cs  input  1  chip select; a bus access is valid only when this input is 1.
REQ-006 Port: wr  input  1  write strobe; a write is cs=1 and wr=1.
REQ-007 Port: rd  input  1  read strobe; a read is cs=1, rd=1 and wr=0.
REQ-008 Port: d_in  input  WIDTH  write data.
REQ-009 Port: d_out  output  WIDTH  read data, registered.
REQ-010 Port: pwm  output  1  PWM waveform, registered.
REQ-011 Port: irq  output  1  level interrupt, equal to status.done AND ctrl.ie.

Function
REQ-012 Register map (byte offsets):
- 0x00 CTRL: bit0 en, bit1 ie; other bits read 0.
- 0x04 PERIOD: shadow register.
- 0x08 DUTY: shadow register.
- 0x0C COUNT: read-only live counter.
- 0x10 STATUS: bit0 done, write-1-to-clear.
- 0x14-0x1C: reserved; writes ignored, reads return 0.
REQ-013 Writes take effect on the clk edge on which cs=1 and wr=1; every write is a single cycle with no wait states.
REQ-014 If wr=1 and rd=1 on the same cycle, the access is treated as a write only.
REQ-015 Read latency is 1 cycle: d_out holds the addressed register value on the edge after cs=1, rd=1.
REQ-016 d_out holds its last value when no read is in progress.
REQ-017 Writes to PERIOD and DUTY update the shadow registers only.
REQ-018 Active period and duty are loaded from the shadows at each of these points:
- the counter wraps to 0;
- en rises from 0 to 1;
- every cycle while en=0.
REQ-019 The counter counts 0 to active_period-1, then returns to 0; it increments once per clk while en=1 and active_period is not 0.
REQ-020 pwm=1 when en=1 and count < active_duty, otherwise 0; pwm is registered, so it lags the counter by one cycle.
REQ-021 Boundary behaviour:
- active_period=0: counter held at 0, pwm=0, done never sets.
- active_duty=0: pwm=0.
- active_duty >= active_period: pwm=1 continuously.
REQ-022 en=0: counter is forced to 0 and pwm=0 on the next edge.
REQ-023 done sets on the cycle the counter wraps from active_period-1 to 0.
REQ-024 If the done set and a write-1-to-clear of done occur on the same edge, set wins and done stays 1.
REQ-025 Writing 0 to STATUS bit0 has no effect.
REQ-026 A COUNT read returns the counter value present at the sampling edge.
REQ-027 All arithmetic is unsigned WIDTH-bit; the counter compare uses active_period-1 and cannot overflow.

Reset
REQ-028 While rst_n=0, asynchronously and without waiting for clk, the following are cleared:
- CTRL=0, PERIOD shadow and active=0, DUTY shadow and active=0;
- counter=0, done=0;
- d_out=0, pwm=0, irq=0.
REQ-029 Reset asserted mid-period forces pwm=0 immediately; after release, no output activity occurs until CTRL.en is written to 1.
REQ-030 Reset release is synchronised to clk internally, so the block leaves reset on a clk edge.

Verification
REQ-031 Basic waveform: write PERIOD=10, DUTY=3, CTRL=1 -> pwm high 3 cycles, low 7 cycles, repeating; done rises every 10 cycles.
REQ-032 Shadow update: mid-period, with count=4, write DUTY=7 -> current period keeps duty 3; duty 7 applies from the next count=0.
REQ-033 Boundaries: DUTY=0 -> pwm constantly 0; DUTY=10 with PERIOD=10 -> pwm constantly 1; PERIOD=0 with en=1 -> COUNT reads 0, pwm=0.
REQ-034 Clear-versus-set: write STATUS=1 on the same edge as a wrap -> done remains 1; a clear on a non-wrap cycle -> done=0 and irq=0.
REQ-035 Readback: with cs=1, rd=1, adr=0x04 -> d_out equals the written PERIOD one cycle later; adr=0x18 -> d_out=0.
REQ-036 Reset mid-run: pull rst_n=0 while pwm=1 -> pwm=0 and d_out=0 before the next clk edge; all registers read 0 after release.

Source files
------------

// File: rtl/pwm_regs_if.sv
// pwm_regs_if - register bus between a bus initiator and pwm_regs.
//   adr   : byte address (initiator -> target)
//   cs    : chip select
//   wr    : write strobe (wins over rd when both are high)
//   rd    : read strobe
//   d_in  : write data
//   d_out : registered read data (target -> initiator)
interface pwm_regs_if #(
    parameter int WIDTH = 32
);
    logic [31:0]      adr;
    logic             cs;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;

    modport master (
        output adr, cs, wr, rd, d_in,
        input  d_out
    );

    modport slave (
        input  adr, cs, wr, rd, d_in,
        output d_out
    );
endinterface

// File: rtl/pwm_regs.sv
// pwm_regs - PWM generator with a small register file.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (release synchronised to clk)
//   bus   : register bus (slave side), see pwm_regs_if
//   pwm   : registered PWM waveform
//   irq   : level interrupt = status.done & ctrl.ie
// Map: 0x00 CTRL {ie,en}, 0x04 PERIOD, 0x08 DUTY, 0x0C COUNT (ro),
//      0x10 STATUS {done} (write 1 to clear), 0x14-0x1C reserved.
// PERIOD/DUTY writes land in shadows; the active copies reload on a wrap
// and every cycle while en=0 (which also covers the 0->1 edge of en).
module pwm_regs #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_regs_if.slave    bus,
    output logic         pwm,
    output logic         irq
);
    localparam logic [2:0] SEL_CTRL   = 3'd0;
    localparam logic [2:0] SEL_PERIOD = 3'd1;
    localparam logic [2:0] SEL_DUTY   = 3'd2;
    localparam logic [2:0] SEL_COUNT  = 3'd3;
    localparam logic [2:0] SEL_STATUS = 3'd4;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [1:0]       rst_sync;
    logic             rst_int_n;
    logic             ctrl_en;
    logic             ctrl_ie;
    logic [WIDTH-1:0] period_shadow;
    logic [WIDTH-1:0] duty_shadow;
    logic [WIDTH-1:0] period_act;
    logic [WIDTH-1:0] duty_act;
    logic [WIDTH-1:0] cnt;
    logic             done;
    logic [2:0]       sel;
    logic             wr_en;
    logic             rd_en;
    logic             running;
    logic             wrap;
    logic             load_act;
    logic             status_clr;
    logic [WIDTH-1:0] rd_data;
    logic             unused_adr;

    // Assertion is immediate through the synchroniser's async clear; release
    // reaches the rest of the block two clk edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign sel        = bus.adr[4:2];
    assign unused_adr = ^{bus.adr[31:5], bus.adr[1:0]};
    assign wr_en      = bus.cs & bus.wr;
    assign rd_en      = bus.cs & bus.rd & ~bus.wr;
    assign status_clr = wr_en && (sel == SEL_STATUS) && bus.d_in[0];

    // Compare against period-1 only when period is nonzero, so no underflow.
    assign running  = ctrl_en && (period_act != '0);
    assign wrap     = running && (cnt == period_act - ONE);
    assign load_act = !ctrl_en || wrap;

    assign irq = done & ctrl_ie;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ctrl_en       <= 1'b0;
            ctrl_ie       <= 1'b0;
            period_shadow <= '0;
            duty_shadow   <= '0;
        end else if (wr_en) begin
            case (sel)
                SEL_CTRL: begin
                    ctrl_en <= bus.d_in[0];
                    ctrl_ie <= bus.d_in[1];
                end
                SEL_PERIOD: period_shadow <= bus.d_in;
                SEL_DUTY:   duty_shadow   <= bus.d_in;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            period_act <= '0;
            duty_act   <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            pwm        <= 1'b0;
        end else begin
            if (load_act) begin
                period_act <= period_shadow;
                duty_act   <= duty_shadow;
            end
            if (!running || wrap) cnt <= '0;
            else                  cnt <= cnt + ONE;
            // A wrap on the same edge as a clear keeps done set.
            done <= wrap | (done & ~status_clr);
            pwm  <= running && (cnt < duty_act);
        end
    end

    always_comb begin
        rd_data = '0;
        case (sel)
            SEL_CTRL:   rd_data = {{(WIDTH-2){1'b0}}, ctrl_ie, ctrl_en};
            SEL_PERIOD: rd_data = period_shadow;
            SEL_DUTY:   rd_data = duty_shadow;
            SEL_COUNT:  rd_data = cnt;
            SEL_STATUS: rd_data = {{(WIDTH-1){1'b0}}, done};
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n)  bus.d_out <= '0;
        else if (rd_en)  bus.d_out <= rd_data;
    end
endmodule

// File: tb/tb_pwm_regs.sv
// tb_pwm_regs - self-checking bench for pwm_regs.
// Reference behaviour is computed arithmetically: after enabling at edge E0,
// the counter value sampled by edge Ek is (k-1) mod P, pwm after Ek is that
// value < D, and done is set from edge EP onward.
module tb_pwm_regs;
    localparam int WIDTH = 32;
    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_PERIOD = 32'h04;
    localparam logic [31:0] A_DUTY   = 32'h08;
    localparam logic [31:0] A_COUNT  = 32'h0C;
    localparam logic [31:0] A_STATUS = 32'h10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm;
    logic irq;
    int checks = 0;
    int errors = 0;

    pwm_regs_if #(.WIDTH(WIDTH)) bus ();

    pwm_regs #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .pwm   (pwm),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.cs = 1'b0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.adr  = a;
        bus.d_in = d;
        bus.cs   = 1'b1;
        bus.wr   = 1'b1;
        bus.rd   = 1'b0;
        tick(1);
        idle();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.adr = a;
        bus.cs  = 1'b1;
        bus.wr  = 1'b0;
        bus.rd  = 1'b1;
        tick(1);
        d = bus.d_out;
        idle();
    endtask

    task automatic disable_and_clear();
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++;
        if (pwm !== 1'b0 || irq !== 1'b0 || bus.d_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs pwm=%b irq=%b d_out=%h want 0", pwm, irq, bus.d_out);
        end
        for (int a = 0; a < 8; a++) begin
            bus_read(32'(a * 4), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_read adr=%h got %h want 0", a * 4, d);
            end
        end
    endtask

    // Enable with period p / duty d and check n cycles against the model.
    task automatic run_check(input string name, input int p, input int d, input int n,
                             input bit ie);
        int c;
        logic exp_pwm, exp_irq;
        disable_and_clear();
        bus_write(A_PERIOD, 32'(p));
        bus_write(A_DUTY, 32'(d));
        bus_write(A_CTRL, ie ? 32'h3 : 32'h1);
        bus.adr = A_COUNT;
        bus.cs  = 1'b1;
        bus.rd  = 1'b1;
        bus.wr  = 1'b0;
        for (int k = 1; k <= n; k++) begin
            tick(1);
            c       = (p == 0) ? 0 : (k - 1) % p;
            exp_pwm = (p != 0) && (c < d);
            exp_irq = ie && (p != 0) && (k >= p);
            checks++;
            if (bus.d_out !== 32'(c) || pwm !== exp_pwm || irq !== exp_irq) begin
                errors++;
                $display("FAIL %s p=%0d d=%0d k=%0d count=%0d/%0d pwm=%b/%b irq=%b/%b (got/want)",
                         name, p, d, k, bus.d_out, c, pwm, exp_pwm, irq, exp_irq);
            end
        end
        idle();
    endtask

    task automatic test_boundaries();
        run_check("duty0", 10, 0, 25, 1'b1);
        run_check("duty_eq_period", 10, 10, 25, 1'b1);
        run_check("duty_gt_period", 4, 9, 12, 1'b0);
        run_check("period0", 0, 5, 15, 1'b1);
        run_check("period1", 1, 1, 6, 1'b1);
    endtask

    task automatic test_random();
        int p, d;
        bit ie;
        for (int i = 0; i < 8; i++) begin
            p  = $urandom_range(0, 12);
            d  = $urandom_range(0, 14);
            ie = 1'($urandom_range(0, 1));
            run_check("random", p, d, 2 * p + 6, ie);
        end
    endtask

    task automatic test_shadow();
        int c, dd;
        logic exp_pwm;
        disable_and_clear();
        bus_write(A_PERIOD, 32'd10);
        bus_write(A_DUTY, 32'd3);
        bus_write(A_CTRL, 32'h1);
        tick(4);
        bus_write(A_DUTY, 32'd7);     // lands on the edge that samples count=4
        bus.adr = A_COUNT;
        bus.cs  = 1'b1;
        bus.rd  = 1'b1;
        for (int k = 6; k <= 32; k++) begin
            tick(1);
            c       = (k - 1) % 10;
            dd      = ((k - 1) / 10 == 0) ? 3 : 7;
            exp_pwm = (c < dd);
            checks++;
            if (bus.d_out !== 32'(c) || pwm !== exp_pwm) begin
                errors++;
                $display("FAIL shadow k=%0d count=%0d/%0d pwm=%b/%b (got/want)",
                         k, bus.d_out, c, pwm, exp_pwm);
            end
        end
        idle();
    endtask

    task automatic test_clear_vs_set();
        logic [31:0] d;
        disable_and_clear();
        bus_write(A_PERIOD, 32'd10);
        bus_write(A_DUTY, 32'd3);
        bus_write(A_CTRL, 32'h3);
        tick(9);
        bus_write(A_STATUS, 32'h1);   // same edge as the wrap
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_set irq got %b want 1", irq);
        end
        bus_write(A_STATUS, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL clr_nonwrap irq got %b want 0", irq);
        end
        tick(9);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL done_again irq got %b want 1", irq);
        end
        bus_write(A_STATUS, 32'h0);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL wr0_noeffect irq got %b want 1", irq);
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL status_read got %h want 1", d);
        end
        bus_write(A_CTRL, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked irq got %b want 0", irq);
        end
        bus_read(A_CTRL, d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL ctrl_read got %h want 1", d);
        end
    endtask

    task automatic test_readback();
        logic [31:0] d, v, w, v2;
        disable_and_clear();
        v  = $urandom;
        w  = $urandom;
        v2 = $urandom;
        bus_write(A_PERIOD, v);
        bus_read(A_PERIOD, d);
        checks++;
        if (d !== v) begin errors++; $display("FAIL rb_period got %h want %h", d, v); end
        bus_read(32'hFFFF_FFE7, d);   // only adr[4:2] decoded
        checks++;
        if (d !== v) begin errors++; $display("FAIL rb_alias got %h want %h", d, v); end
        bus_read(32'h18, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rb_reserved got %h want 0", d); end
        bus_write(A_DUTY, w);
        bus_read(A_DUTY, d);
        checks++;
        if (d !== w) begin errors++; $display("FAIL rb_duty got %h want %h", d, w); end
        tick(2);
        checks++;
        if (bus.d_out !== w) begin errors++; $display("FAIL rb_hold got %h want %h", bus.d_out, w); end
        // wr and rd together is a write only: d_out must not move
        bus.adr  = A_PERIOD;
        bus.d_in = v2;
        bus.cs   = 1'b1;
        bus.wr   = 1'b1;
        bus.rd   = 1'b1;
        tick(1);
        idle();
        checks++;
        if (bus.d_out !== w) begin errors++; $display("FAIL rb_wr_rd_hold got %h want %h", bus.d_out, w); end
        bus_read(A_PERIOD, d);
        checks++;
        if (d !== v2) begin errors++; $display("FAIL rb_wr_rd_write got %h want %h", d, v2); end
        bus_write(32'h1C, 32'hFFFF_FFFF);
        bus_read(32'h1C, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rb_reserved_wr got %h want 0", d); end
        bus_write(A_CTRL, 32'hFFFF_FFFC);
        bus_read(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rb_ctrl_bits got %h want 0", d); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        disable_and_clear();
        bus_write(A_PERIOD, 32'd10);
        bus_write(A_DUTY, 32'd3);
        bus_write(A_CTRL, 32'h3);
        bus_read(A_PERIOD, d);
        checks++;
        if (pwm !== 1'b1 || d !== 32'd10) begin
            errors++;
            $display("FAIL midrun_pre pwm=%b want 1 d_out=%0d want 10", pwm, d);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pwm !== 1'b0 || bus.d_out !== '0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL midrun_async pwm=%b d_out=%h irq=%b want 0", pwm, bus.d_out, irq);
        end
        tick(2);
        #3;
        rst_n = 1'b1;
        tick(3);
        for (int a = 0; a < 8; a++) begin
            bus_read(32'(a * 4), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL midrun_read adr=%h got %h want 0", a * 4, d);
            end
        end
        for (int k = 0; k < 12; k++) begin
            tick(1);
            checks++;
            if (pwm !== 1'b0 || irq !== 1'b0) begin
                errors++;
                $display("FAIL midrun_quiet k=%0d pwm=%b irq=%b want 0", k, pwm, irq);
            end
        end
    endtask

    initial begin
        idle();
        bus.adr  = '0;
        bus.d_in = '0;
        rst_n    = 1'b0;
        tick(3);
        #3;
        rst_n = 1'b1;
        tick(3);
        test_reset();
        run_check("basic", 10, 3, 30, 1'b1);
        test_shadow();
        test_boundaries();
        test_clear_vs_set();
        test_readback();
        test_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
